// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator: FSM state encoding and
// the width of the incoming partial sums.
package sum_accumulator_pkg;
  localparam int SUM_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;
endpackage

// File: rtl/acc_adder.sv
// Combinational W-bit adder with carry out; the carry feeds the overflow flag.
module acc_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT 3-bit sums per batch into an ACC_W-bit total with a
// sticky overflow flag, then presents the result under a valid/ready handshake.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [SUM_W-1:0] in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf,
  output logic             busy
);
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT);

  state_e           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_in_ext;
  logic             r_ovf;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  assign w_in_ext  = ACC_W'(in_sum);
  assign w_accept  = in_valid && (r_state == ACCUM);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_last    = (w_cnt_inc == LAST);

  acc_adder #(.W(ACC_W)) u_add (
    .a    (r_acc),
    .b    (w_in_ext),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ACCUM;
      ACCUM:   if (w_accept && w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The accumulator doubles as the result register, so IDLE keeps showing
  // the previous batch until a new start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == IDLE && start) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_ovf <= r_ovf | w_cout;
      r_cnt <= w_cnt_inc;
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_total = r_acc;
  assign out_ovf   = r_ovf;
endmodule

// File: tb/tb_sum_accumulator.sv
// Drives two accumulators (8-bit and 4-bit totals) with the same batches and
// checks them against a plain arithmetic model of each batch.
module tb_sum_accumulator;
  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic [2:0] in_sum;

  logic       rdy_a, vld_a, ovf_a, busy_a;
  logic [7:0] tot_a;
  logic       rdy_b, vld_b, ovf_b, busy_b;
  logic [3:0] tot_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.COUNT(4), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(rdy_a), .out_valid(vld_a), .out_ready(out_ready),
    .out_total(tot_a), .out_ovf(ovf_a), .busy(busy_a)
  );

  sum_accumulator #(.COUNT(4), .ACC_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(rdy_b), .out_valid(vld_b), .out_ready(out_ready),
    .out_total(tot_b), .out_ovf(ovf_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected result of a batch whose plain (unbounded) sum is s.
  task automatic chk_result(input string tag, input int s);
    chk({tag, "_tot8"}, int'(tot_a), s % 256);
    chk({tag, "_ovf8"}, int'(ovf_a), (s > 255) ? 1 : 0);
    chk({tag, "_tot4"}, int'(tot_b), s % 16);
    chk({tag, "_ovf4"}, int'(ovf_b), (s > 15) ? 1 : 0);
  endtask

  task automatic chk_ctl(input string tag, input int rdy, input int vld, input int bsy);
    chk({tag, "_rdy"}, int'(rdy_a) + 2 * int'(rdy_b), 3 * rdy);
    chk({tag, "_vld"}, int'(vld_a) + 2 * int'(vld_b), 3 * vld);
    chk({tag, "_busy"}, int'(busy_a) + 2 * int'(busy_b), 3 * bsy);
  endtask

  task automatic send(input int v);
    in_valid = 1'b1;
    in_sum   = 3'(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // gaps: bit i inserts an idle cycle before sample i; hold: DONE cycles with out_ready low.
  task automatic batch(input string tag, input int v0, input int v1, input int v2,
                       input int v3, input int gaps, input int hold, input bit smid);
    int v[4];
    int s;
    v = '{v0, v1, v2, v3};
    s = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_ctl({tag, "_acc"}, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      if (gaps[i]) @(negedge clk);
      if (smid && i == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send(v[i]);
      s += v[i];
      if (i < 3) chk({tag, "_early_vld"}, int'(vld_a) + int'(vld_b), 0);
    end
    chk_ctl({tag, "_done"}, 0, 1, 1);
    chk_result({tag, "_done"}, s);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk_ctl({tag, "_hold"}, 0, 1, 1);
      chk_result({tag, "_hold"}, s);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_ctl({tag, "_idle"}, 0, 0, 0);
    chk_result({tag, "_idle"}, s);
    if (smid) begin
      @(negedge clk);
      chk_ctl({tag, "_nopend"}, 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    #1;
    chk_ctl("reset", 0, 0, 0);
    chk_result("reset", 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_ctl("post_rst", 0, 0, 0);

    batch("basic", 3, 5, 6, 1, 0, 0, 1'b0);
    batch("ovf", 6, 6, 6, 6, 0, 0, 1'b0);
    batch("b2b", 1, 2, 0, 3, 0, 0, 1'b0);
    batch("gaps", 2, 2, 2, 2, 4'b1110, 5, 1'b0);
    batch("smid", 1, 1, 1, 1, 0, 0, 1'b1);
    batch("sev", 7, 7, 0, 1, 0, 1, 1'b0);

    // Reset mid-batch.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(5);
    send(6);
    rst = 1'b1;
    #1;
    chk_ctl("midrst", 0, 0, 0);
    chk_result("midrst", 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_ctl("midrst_wait", 0, 0, 0);
    chk_result("midrst_wait", 0);
    batch("fresh", 1, 1, 1, 1, 0, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int r[4];
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
      batch($sformatf("rnd%0d", n), r[0], r[1], r[2], r[3],
            $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
